ttc_orbit_tmr: RTL and testbench

Parametrised TTC bunch/orbit timing block for the OptoHybrid control path. It keeps a local bunch-crossing counter and orbit counter aligned to the incoming TTC BX0 and resync commands. It generates the local BX0 strobe, detects and counts BX0 misalignment, and optionally triplicates its state with per-cycle voting and self-correction. It replaces the fixed-width TTC TMR wrapper in the control block and feeds trigger/DAQ timestamping.

---
 rtl/ttc_orbit_tmr.sv | 169 ++++++++++++++++
 tb/tb_ttc_orbit_tmr.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ttc_orbit_tmr.sv
// TTC bunch/orbit counter with BX0 alignment check and sticky/counted sync errors.
// Define TTC_ORBIT_TMR_EN to triplicate the state with 2-of-3 voting and self-correction.
module ttc_orbit_tmr #(
  parameter int unsigned HOLD_UNTIL_BX0 = 0,
  parameter int unsigned MXBXN          = 12,
  parameter int unsigned BX_PER_ORBIT   = 3564,
  parameter int unsigned MXORB          = 16,
  parameter int unsigned MXCNT          = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ttc_bx0,
  input  logic             ttc_resync,
  input  logic [MXBXN-1:0] bxn_offset,
  output logic [MXBXN-1:0] bxn_counter,
  output logic [MXORB-1:0] orbit_counter,
  output logic             bx0_local,
  output logic             bx0_sync_err,
  output logic             bxn_sync_err,
  output logic [MXCNT-1:0] sync_err_cnt,
  output logic             tmr_err,
  output logic [MXCNT-1:0] tmr_err_cnt
);

  typedef enum logic {
    S_WAIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    state_e           state;
    logic [MXBXN-1:0] bxn;
    logic [MXORB-1:0] orbit;
    logic             serr;
    logic [MXCNT-1:0] scnt;
  } st_t;

  localparam int unsigned      SW        = $bits(st_t);
  localparam logic [MXBXN-1:0] LAST_BX   = MXBXN'(BX_PER_ORBIT - 1);
  localparam state_e           RST_STATE = (HOLD_UNTIL_BX0 != 0) ? S_WAIT : S_RUN;

  logic [MXBXN-1:0] off_c;
  logic             bx0_local_c;
  logic             perr_d;
  logic             perr_q;
  st_t              st_v;
  st_t              st_d;
  st_t              st_rst_c;

  function automatic logic [MXBXN-1:0] bx_inc(input logic [MXBXN-1:0] b);
    return (b == LAST_BX) ? '0 : b + MXBXN'(1);
  endfunction

  // Offsets beyond the orbit length are clamped to the last bunch.
  assign off_c       = (bxn_offset > LAST_BX) ? LAST_BX : bxn_offset;
  assign bx0_local_c = (st_v.state == S_RUN) && (st_v.bxn == off_c);

  always_comb begin
    st_rst_c       = st_v;
    st_rst_c.state = RST_STATE;
    st_rst_c.bxn   = off_c;
    st_rst_c.orbit = '0;
    st_rst_c.serr  = 1'b0;
    st_rst_c.scnt  = '0;
  end

  // Next state is always derived from the voted (or single) current state.
  always_comb begin
    st_d   = st_v;
    perr_d = 1'b0;
    if (ttc_resync) begin
      st_d.state = RST_STATE;
      st_d.bxn   = off_c;
      st_d.orbit = '0;
      st_d.serr  = 1'b0;
    end else if (st_v.state == S_WAIT) begin
      st_d.bxn   = off_c;
      st_d.orbit = '0;
      if (ttc_bx0) begin
        st_d.state = S_RUN;
        st_d.bxn   = bx_inc(off_c);
      end
    end else begin
      st_d.bxn = bx_inc(st_v.bxn);
      if (bx0_local_c) begin
        st_d.orbit = st_v.orbit + MXORB'(1);
      end
      // Misaligned BX0 is flagged and counted but never realigns the counter.
      if (ttc_bx0 && (st_v.bxn != off_c)) begin
        perr_d    = 1'b1;
        st_d.serr = 1'b1;
        if (st_v.scnt != '1) begin
          st_d.scnt = st_v.scnt + MXCNT'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

`ifdef TTC_ORBIT_TMR_EN
  logic [SW-1:0]    c0;
  logic [SW-1:0]    c1;
  logic [SW-1:0]    c2;
  logic             tmr_mis_c;
  logic             tmr_err_q;
  logic [MXCNT-1:0] tmr_cnt_q;

  for (genvar g = 0; g < 3; g++) begin : g_copy
    (* dont_touch = "true" *) st_t st_q;
    always_ff @(posedge clock) begin
      if (reset) begin
        st_q <= st_rst_c;
      end else begin
        st_q <= st_d;
      end
    end
  end

  assign c0        = g_copy[0].st_q;
  assign c1        = g_copy[1].st_q;
  assign c2        = g_copy[2].st_q;
  assign st_v      = st_t'((c0 & c1) | (c0 & c2) | (c1 & c2));
  assign tmr_mis_c = (c0 != c1) || (c0 != c2);

  always_ff @(posedge clock) begin
    if (reset) begin
      tmr_err_q <= 1'b0;
      tmr_cnt_q <= '0;
    end else begin
      tmr_err_q <= tmr_mis_c;
      if (tmr_mis_c && (tmr_cnt_q != '1)) begin
        tmr_cnt_q <= tmr_cnt_q + MXCNT'(1);
      end
    end
  end

  assign tmr_err     = tmr_err_q;
  assign tmr_err_cnt = tmr_cnt_q;
`else
  st_t st_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q <= st_rst_c;
    end else begin
      st_q <= st_d;
    end
  end

  assign st_v        = st_q;
  assign tmr_err     = 1'b0;
  assign tmr_err_cnt = '0;
`endif

  assign bxn_counter   = st_v.bxn;
  assign orbit_counter = st_v.orbit;
  assign bx0_local     = bx0_local_c;
  assign bx0_sync_err  = perr_q;
  assign bxn_sync_err  = st_v.serr;
  assign sync_err_cnt  = st_v.scnt;

endmodule

// File: tb/tb_ttc_orbit_tmr.sv
// Bench for ttc_orbit_tmr: free-running instance (offset 0, 4-bit counters) and hold-until-BX0 instance (offset 5).
module tb_ttc_orbit_tmr;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst0, bx0_0, rs0;
  logic [11:0] off0;
  logic [11:0] bxn0;
  logic [15:0] orb0;
  logic        bl0, pe0, se0, te0;
  logic [3:0]  cnt0, tcnt0;

  logic        rst1, bx0_1, rs1;
  logic [11:0] off1;
  logic [11:0] bxn1;
  logic [15:0] orb1;
  logic        bl1, pe1, se1, te1;
  logic [15:0] cnt1, tcnt1;

  ttc_orbit_tmr #(
    .HOLD_UNTIL_BX0(0), .MXBXN(12), .BX_PER_ORBIT(3564), .MXORB(16), .MXCNT(4)
  ) u0 (
    .clock(clock), .reset(rst0), .ttc_bx0(bx0_0), .ttc_resync(rs0), .bxn_offset(off0),
    .bxn_counter(bxn0), .orbit_counter(orb0), .bx0_local(bl0), .bx0_sync_err(pe0),
    .bxn_sync_err(se0), .sync_err_cnt(cnt0), .tmr_err(te0), .tmr_err_cnt(tcnt0)
  );

  ttc_orbit_tmr #(
    .HOLD_UNTIL_BX0(1), .MXBXN(12), .BX_PER_ORBIT(3564), .MXORB(16), .MXCNT(16)
  ) u1 (
    .clock(clock), .reset(rst1), .ttc_bx0(bx0_1), .ttc_resync(rs1), .bxn_offset(off1),
    .bxn_counter(bxn1), .orbit_counter(orb1), .bx0_local(bl1), .bx0_sync_err(pe1),
    .bxn_sync_err(se1), .sync_err_cnt(cnt1), .tmr_err(te1), .tmr_err_cnt(tcnt1)
  );

  typedef struct {
    int          inst;
    logic        rst;
    logic        bx0;
    logic        rs;
    logic [11:0] off;
    logic [11:0] bxn;
    logic [15:0] orb;
    logic        bl;
    logic        pe;
    logic        se;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void add(input int inst, input logic rst, input logic bx0, input logic rs,
                              input logic [11:0] off, input logic [11:0] bxn, input logic [15:0] orb,
                              input logic bl, input logic pe, input logic se, input logic [15:0] cnt);
    vec_t v;
    v.inst = inst; v.rst = rst; v.bx0 = bx0; v.rs = rs; v.off = off;
    v.bxn = bxn; v.orb = orb; v.bl = bl; v.pe = pe; v.se = se; v.cnt = cnt;
    tbl.push_back(v);
  endfunction

  task automatic check_vec(input vec_t e, input int idx);
    logic [11:0] a_bxn;
    logic [15:0] a_orb, a_cnt;
    logic        a_bl, a_pe, a_se, a_te;
    if (e.inst == 0) begin
      a_bxn = bxn0; a_orb = orb0; a_bl = bl0; a_pe = pe0; a_se = se0; a_cnt = 16'(cnt0); a_te = te0;
    end else begin
      a_bxn = bxn1; a_orb = orb1; a_bl = bl1; a_pe = pe1; a_se = se1; a_cnt = cnt1; a_te = te1;
    end
    total++;
    if ({a_bxn, a_orb, a_bl, a_pe, a_se, a_cnt, a_te} !== {e.bxn, e.orb, e.bl, e.pe, e.se, e.cnt, 1'b0}) begin
      bad++;
      $display("FAIL vec%0d inst%0d: got bxn=%0d orb=%0d bl=%b pe=%b se=%b cnt=%0d te=%b, want bxn=%0d orb=%0d bl=%b pe=%b se=%b cnt=%0d te=0",
               idx, e.inst, a_bxn, a_orb, a_bl, a_pe, a_se, a_cnt, a_te,
               e.bxn, e.orb, e.bl, e.pe, e.se, e.cnt);
    end
  endtask

  task automatic run_tbl();
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      vec_t e;
      v = tbl[i];
      @(negedge clock);
      rst0 = 1'b0; bx0_0 = 1'b0; rs0 = 1'b0;
      rst1 = 1'b0; bx0_1 = 1'b0; rs1 = 1'b0;
      if (v.inst == 0) begin
        rst0 = v.rst; bx0_0 = v.bx0; rs0 = v.rs; off0 = v.off;
      end else begin
        rst1 = v.rst; bx0_1 = v.bx0; rs1 = v.rs; off1 = v.off;
      end
      sb.push_back(v);
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty vec%0d: got no entry, want one", i);
      end else begin
        e = sb.pop_front();
        check_vec(e, i);
      end
    end
    tbl.delete();
  endtask

`ifdef TTC_ORBIT_TMR_EN
  logic [33:0] snap;
  logic [11:0] b_before;
  logic [11:0] b_next;
`endif

  initial begin
    rst0 = 1'b1; bx0_0 = 1'b0; rs0 = 1'b0; off0 = 12'd0;
    rst1 = 1'b1; bx0_1 = 1'b0; rs1 = 1'b0; off1 = 12'd5;

    // Instance 0: free-running, offset 0, 4-bit error counter.
    add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 3563; i++) add(0, 0, 0, 0, 0, 12'(i), 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
    for (int i = 2; i <= 10; i++) add(0, 0, 0, 0, 0, 12'(i), 2, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 11, 2, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 12, 2, 0, 0, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    for (int k = 1; k <= 19; k++) add(0, 0, 1, 0, 0, 12'(1 + k), 1, 0, 1, 1, 16'((1 + k > 15) ? 15 : 1 + k));
    add(0, 0, 0, 0, 0, 21, 1, 0, 0, 1, 15);
    add(0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 15);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 15);
    add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 4095, 3563, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 4095, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 4095, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
    run_tbl();

`ifdef TTC_ORBIT_TMR_EN
    @(negedge clock);
    b_before = bxn0;
    b_next   = (b_before == 12'd3563) ? 12'd0 : b_before + 12'd1;
    snap     = u0.g_copy[1].st_q;
    force u0.g_copy[1].st_q = snap ^ (34'(1) << 24);
    #1;
    release u0.g_copy[1].st_q;
    total++;
    if (bxn0 !== b_before) begin
      bad++;
      $display("FAIL tmr_vote: got bxn=%0d, want %0d", bxn0, b_before);
    end
    @(posedge clock);
    #1;
    total++;
    if (te0 !== 1'b1 || tcnt0 !== 4'd1) begin
      bad++;
      $display("FAIL tmr_pulse: got te=%b cnt=%0d, want te=1 cnt=1", te0, tcnt0);
    end
    total++;
    if (u0.g_copy[0].st_q !== u0.g_copy[1].st_q || u0.g_copy[0].st_q !== u0.g_copy[2].st_q || bxn0 !== b_next) begin
      bad++;
      $display("FAIL tmr_correct: got bxn=%0d copies_equal=%b, want bxn=%0d copies_equal=1", bxn0,
               (u0.g_copy[0].st_q == u0.g_copy[1].st_q) && (u0.g_copy[0].st_q == u0.g_copy[2].st_q), b_next);
    end
    @(posedge clock);
    #1;
    total++;
    if (te0 !== 1'b0 || tcnt0 !== 4'd1) begin
      bad++;
      $display("FAIL tmr_clear: got te=%b cnt=%0d, want te=0 cnt=1", te0, tcnt0);
    end
`endif

    // Instance 1: hold until BX0, offset 5.
    add(1, 1, 0, 0, 5, 5, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 5, 5, 0, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) add(1, 0, 0, 0, 5, 5, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 5, 6, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 5, 7, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 5, 8, 0, 0, 1, 1, 1);
    add(1, 0, 1, 1, 5, 5, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 5, 5, 0, 0, 0, 0, 1);
    add(1, 0, 1, 0, 5, 6, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 5, 7, 0, 0, 0, 0, 1);
    run_tbl();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
